scrub_ctrl: RTL and testbench



---
 rtl/scrub_ctrl_if.sv | 28 ++
 rtl/scrub_ctrl.sv | 149 ++++++++++++++
 tb/tb_scrub_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scrub_ctrl_if.sv
// Host request/response and single-port RAM command bundle for scrub_ctrl.
// slave = controller view, master = host plus RAM view.
interface scrub_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [9:0]        host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [9:0]        host_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [9:0]        ram_wr_data;
  logic              ram_rd_en;
  logic              ram_wr_en;
  logic [9:0]        ram_rd_data;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, ram_rd_data,
    output host_gnt, host_rvalid, host_rdata, ram_addr, ram_wr_data, ram_rd_en, ram_wr_en
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata, ram_rd_data,
    input  host_gnt, host_rvalid, host_rdata, ram_addr, ram_wr_data, ram_rd_en, ram_wr_en
  );
endinterface

// File: rtl/scrub_ctrl.sv
// Scrubber for a small RAM: periodic golden-pattern walk with rewrite of bad words; RAM commands are combinational.
// The host always wins the single RAM port; the scrub step stalls on contention, except CMP, which needs no port slot.
module scrub_ctrl #(
  parameter int         NUM_WORDS      = 4,
  parameter int         ADDR_W         = 4,
  parameter int         SCRUB_INTERVAL = 1024,
  parameter logic [9:0] GOLD_EVEN      = 10'h3FF,
  parameter logic [9:0] GOLD_ODD       = 10'h000,
  parameter int         CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scrub_en,
  input  logic             scrub_force,
  scrub_ctrl_if.slave      bus,
  output logic [CNT_W-1:0] err_cnt,
  output logic             scrub_busy,
  output logic             scrub_done
);

  localparam int                IW      = $clog2(SCRUB_INTERVAL);
  localparam logic [IW-1:0]     IV_LAST = IW'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CMP, S_WR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IW-1:0]     ivl_q, ivl_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              mism_q, mism_d;
  logic              done_q, done_d;
  logic              rvalid_q, rvalid_d;

  function automatic logic [9:0] golden(input logic [ADDR_W-1:0] a);
    return a[0] ? GOLD_ODD : GOLD_EVEN;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      ivl_q    <= '0;
      err_q    <= '0;
      mism_q   <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ivl_q    <= ivl_d;
      err_q    <= err_d;
      mism_q   <= mism_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ivl_d    = ivl_q;
    err_d    = err_q;
    mism_d   = mism_q;
    done_d   = 1'b0;
    rvalid_d = bus.host_req & ~bus.host_we;
    case (state_q)
      S_IDLE: begin
        // A host access in IDLE freezes the interval count so a due pass starts right after it.
        if (!scrub_en)          ivl_d = '0;
        else if (!bus.host_req) ivl_d = ivl_q + IW'(1);
        if (!bus.host_req && ((scrub_en && ivl_q == IV_LAST) || scrub_force)) begin
          state_d = S_RD;
          addr_d  = '0;
          ivl_d   = '0;
        end
      end
      S_RD: begin
        if (!bus.host_req) state_d = S_CMP;
      end
      S_CMP: begin
        mism_d = (bus.ram_rd_data != golden(addr_q));
        if (mism_d) begin
          state_d = S_WR;
        end else if (addr_q == A_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RD;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      S_WR: begin
        if (!bus.host_req) begin
          if (mism_q && err_q != '1) err_d = err_q + CNT_W'(1);
          mism_d = 1'b0;
          if (addr_q == A_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD;
            addr_d  = addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.host_gnt    = 1'b0;
    bus.ram_addr    = '0;
    bus.ram_wr_data = '0;
    bus.ram_rd_en   = 1'b0;
    bus.ram_wr_en   = 1'b0;
    if (rst_n) begin
      if (bus.host_req) begin
        bus.host_gnt = 1'b1;
        bus.ram_addr = bus.host_addr;
        if (bus.host_we) begin
          bus.ram_wr_en   = 1'b1;
          bus.ram_wr_data = bus.host_wdata;
        end else begin
          bus.ram_rd_en = 1'b1;
        end
      end else begin
        case (state_q)
          S_RD: begin
            bus.ram_rd_en = 1'b1;
            bus.ram_addr  = addr_q;
          end
          S_WR: begin
            bus.ram_wr_en   = 1'b1;
            bus.ram_addr    = addr_q;
            bus.ram_wr_data = golden(addr_q);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = bus.ram_rd_data;
  assign err_cnt         = err_q;
  assign scrub_busy      = (state_q != S_IDLE);
  assign scrub_done      = done_q;

endmodule

// File: tb/tb_scrub_ctrl.sv
// Bench for scrub_ctrl: behavioural RAM, per-scenario tasks and a per-cycle monitor for port exclusivity and read returns.
`timescale 1ns/1ps
module tb_scrub_ctrl;
  localparam int         NW   = 4;
  localparam int         AW   = 4;
  localparam int         INTV = 16;
  localparam int         CW   = 2;
  localparam int         SAT  = (1 << CW) - 1;
  localparam logic [9:0] GE   = 10'h3FF;
  localparam logic [9:0] GO   = 10'h000;

  logic          clk = 1'b0;
  logic          rst_n, scrub_en, scrub_force;
  logic [CW-1:0] err_cnt;
  logic          scrub_busy, scrub_done;
  int            checks = 0;
  int            errors = 0;
  int            exp_err = 0;
  logic [9:0]    mem [16];
  int            wr_addr_q[$];
  logic [9:0]    wr_data_q[$];
  int            rd_addr_q[$];
  logic          pend_rv = 1'b0;
  logic [9:0]    pend_rd = '0;

  scrub_ctrl_if #(.ADDR_W(AW)) bus ();

  scrub_ctrl #(.NUM_WORDS(NW), .ADDR_W(AW), .SCRUB_INTERVAL(INTV), .GOLD_EVEN(GE),
               .GOLD_ODD(GO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .scrub_force(scrub_force), .bus(bus),
    .err_cnt(err_cnt), .scrub_busy(scrub_busy), .scrub_done(scrub_done));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wr_data;
    if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_addr];
  end

  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      pend_rv = 1'b0;
    end else begin
      checks++;
      if (bus.ram_rd_en && bus.ram_wr_en) begin
        errors++; $display("FAIL rd_wr_exclusive got rd=%b wr=%b want not both", bus.ram_rd_en, bus.ram_wr_en);
      end
      checks++;
      if (bus.host_rvalid !== pend_rv) begin
        errors++; $display("FAIL host_rvalid got %b want %b at %0t", bus.host_rvalid, pend_rv, $time);
      end
      if (pend_rv) begin
        checks++;
        if (bus.host_rdata !== pend_rd) begin
          errors++; $display("FAIL host_rdata got %h want %h", bus.host_rdata, pend_rd);
        end
      end
      pend_rv = bus.host_req && !bus.host_we;
      pend_rd = mem[bus.host_addr];
    end
  end

  function automatic logic [9:0] gold(input int a);
    return (a % 2 == 0) ? GE : GO;
  endfunction

  function automatic int sat_add(input int base, input int k);
    return (base + k > SAT) ? SAT : base + k;
  endfunction

  task automatic host_op(input logic we, input int a, input logic [9:0] d);
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = AW'(a); bus.host_wdata = d;
    @(negedge clk);
    bus.host_req = 1'b0; bus.host_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 0;
  endtask

  task automatic force_pass();
    scrub_force = 1'b1;
    @(negedge clk);
    scrub_force = 1'b0;
  endtask

  // Observes a running pass until scrub_done; optionally injects random host reads.
  task automatic watch_pass(input int pct, output int busy, output int dn, output logic tmo);
    busy = 0; dn = 0; tmo = 1'b1;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    for (int i = 0; i < 200; i++) begin
      if (pct > 0) begin
        bus.host_req  = ($urandom_range(99) < pct);
        bus.host_we   = 1'b0;
        bus.host_addr = AW'($urandom_range(NW - 1));
      end
      #1;
      if (scrub_busy) busy++;
      if (!bus.host_req && bus.ram_wr_en) begin
        wr_addr_q.push_back(int'(bus.ram_addr)); wr_data_q.push_back(bus.ram_wr_data);
      end
      if (!bus.host_req && bus.ram_rd_en) rd_addr_q.push_back(int'(bus.ram_addr));
      if (scrub_done) dn++;
      @(negedge clk);
      if (dn > 0) begin tmo = 1'b0; break; end
    end
    bus.host_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 4'd5; bus.host_wdata = 10'h155;
    #1;
    checks++; if (bus.host_gnt !== 1'b0)     begin errors++; $display("FAIL rst_gnt got %b want 0", bus.host_gnt); end
    checks++; if (bus.ram_wr_en !== 1'b0)    begin errors++; $display("FAIL rst_wr_en got %b want 0", bus.ram_wr_en); end
    checks++; if (bus.ram_rd_en !== 1'b0)    begin errors++; $display("FAIL rst_rd_en got %b want 0", bus.ram_rd_en); end
    checks++; if (bus.ram_addr !== '0)       begin errors++; $display("FAIL rst_addr got %h want 0", bus.ram_addr); end
    checks++; if (bus.ram_wr_data !== '0)    begin errors++; $display("FAIL rst_wdata got %h want 0", bus.ram_wr_data); end
    checks++; if (err_cnt !== '0)            begin errors++; $display("FAIL rst_err got %0d want 0", err_cnt); end
    checks++; if (scrub_busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b want 0", scrub_busy); end
    checks++; if (scrub_done !== 1'b0)       begin errors++; $display("FAIL rst_done got %b want 0", scrub_done); end
    checks++; if (bus.host_rvalid !== 1'b0)  begin errors++; $display("FAIL rst_rvalid got %b want 0", bus.host_rvalid); end
    bus.host_req = 1'b0; bus.host_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 4'd1; bus.host_wdata = GO;
    #1;
    checks++; if (bus.host_gnt !== 1'b1 || bus.ram_wr_en !== 1'b1 || bus.ram_rd_en !== 1'b0)
      begin errors++; $display("FAIL host_wr_cmd got gnt=%b wr=%b rd=%b want 1 1 0", bus.host_gnt, bus.ram_wr_en, bus.ram_rd_en); end
    checks++; if (bus.ram_addr !== 4'd1 || bus.ram_wr_data !== GO)
      begin errors++; $display("FAIL host_wr_bus got addr=%h data=%h want 1 %h", bus.ram_addr, bus.ram_wr_data, GO); end
    @(negedge clk);
    bus.host_req = 1'b0; bus.host_we = 1'b0;
    host_op(1'b1, 0, GE); host_op(1'b1, 2, GE); host_op(1'b1, 3, GO);
    checks++; if (scrub_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", scrub_busy); end
  endtask

  task automatic test_periodic();
    logic er, ed, eb;
    int   ea;
    do_reset();
    scrub_en = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      eb = (c >= INTV) && (c < INTV + 2 * NW);
      er = eb && ((c - INTV) % 2 == 0);
      ea = (c - INTV) / 2;
      ed = (c == INTV + 2 * NW);
      #1;
      checks++; if (bus.ram_rd_en !== er) begin errors++; $display("FAIL per_rd c=%0d got %b want %b", c, bus.ram_rd_en, er); end
      if (er) begin
        checks++; if (int'(bus.ram_addr) != ea) begin errors++; $display("FAIL per_addr c=%0d got %0d want %0d", c, bus.ram_addr, ea); end
      end
      checks++; if (bus.ram_wr_en !== 1'b0) begin errors++; $display("FAIL per_wr c=%0d got %b want 0", c, bus.ram_wr_en); end
      checks++; if (scrub_done !== ed) begin errors++; $display("FAIL per_done c=%0d got %b want %b", c, scrub_done, ed); end
      checks++; if (scrub_busy !== eb) begin errors++; $display("FAIL per_busy c=%0d got %b want %b", c, scrub_busy, eb); end
      @(negedge clk);
    end
    scrub_en = 1'b0;
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL per_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_force_correct();
    int busy, dn; logic tmo;
    host_op(1'b1, 2, 10'h155);
    force_pass();
    watch_pass(0, busy, dn, tmo);
    exp_err = sat_add(exp_err, 1);
    checks++; if (tmo || dn != 1) begin errors++; $display("FAIL fc_done got tmo=%b dn=%0d want 0 1", tmo, dn); end
    checks++; if (busy != 2 * NW + 1) begin errors++; $display("FAIL fc_len got %0d want %0d", busy, 2 * NW + 1); end
    checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != 2 || wr_data_q[0] !== GE)
      begin errors++; $display("FAIL fc_wr got n=%0d want one write of %h to 2", wr_addr_q.size(), GE); end
    checks++; if (rd_addr_q != '{0, 1, 2, 3}) begin errors++; $display("FAIL fc_rd got n=%0d want reads 0..3", rd_addr_q.size()); end
    checks++; if (err_cnt !== CW'(exp_err)) begin errors++; $display("FAIL fc_err got %0d want %0d", err_cnt, exp_err); end
    host_op(1'b0, 2, 10'h000);
    #1;
    checks++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== GE)
      begin errors++; $display("FAIL fc_readback got v=%b d=%h want 1 %h", bus.host_rvalid, bus.host_rdata, GE); end
    @(negedge clk);
  endtask

  task automatic test_host_stall();
    int busy, dn; logic tmo;
    force_pass();
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 4'd1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) bus.host_req = 1'b0;
      #1;
      checks++; if (bus.host_gnt !== (i < 3)) begin errors++; $display("FAIL st_gnt i=%0d got %b", i, bus.host_gnt); end
      checks++; if (bus.ram_rd_en !== (i <= 3)) begin errors++; $display("FAIL st_rd i=%0d got %b", i, bus.ram_rd_en); end
      if (i <= 3) begin
        checks++; if (bus.ram_addr !== ((i < 3) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL st_addr i=%0d got %0d", i, bus.ram_addr); end
      end
      checks++; if (bus.host_rvalid !== (i >= 1 && i <= 3)) begin errors++; $display("FAIL st_rvalid i=%0d got %b", i, bus.host_rvalid); end
      @(negedge clk);
    end
    watch_pass(0, busy, dn, tmo);
    checks++; if (tmo || dn != 1 || busy != 2 * NW + 3 - 5)
      begin errors++; $display("FAIL st_rest got tmo=%b dn=%0d busy=%0d want 0 1 %0d", tmo, dn, busy, 2 * NW - 2); end
    checks++; if (err_cnt !== CW'(exp_err)) begin errors++; $display("FAIL st_err got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_cmp_host();
    int busy, dn; logic tmo;
    host_op(1'b1, 0, 10'h2AA);
    force_pass();
    #1;
    checks++; if (bus.ram_rd_en !== 1'b1 || bus.ram_addr !== 4'd0) begin errors++; $display("FAIL ch_rd got %b %0d want 1 0", bus.ram_rd_en, bus.ram_addr); end
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 4'd3;
    #1;
    checks++; if (bus.host_gnt !== 1'b1 || bus.ram_rd_en !== 1'b1 || bus.ram_addr !== 4'd3)
      begin errors++; $display("FAIL ch_host got gnt=%b rd=%b addr=%0d want 1 1 3", bus.host_gnt, bus.ram_rd_en, bus.ram_addr); end
    @(negedge clk);
    bus.host_req = 1'b0;
    #1;
    checks++; if (bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 4'd0 || bus.ram_wr_data !== GE)
      begin errors++; $display("FAIL ch_wr got wr=%b addr=%0d data=%h want 1 0 %h", bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data, GE); end
    checks++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== GO)
      begin errors++; $display("FAIL ch_rdata got v=%b d=%h want 1 %h", bus.host_rvalid, bus.host_rdata, GO); end
    @(negedge clk);
    watch_pass(0, busy, dn, tmo);
    exp_err = sat_add(exp_err, 1);
    checks++; if (tmo || dn != 1 || busy != 2 * (NW - 1)) begin errors++; $display("FAIL ch_rest got tmo=%b dn=%0d busy=%0d", tmo, dn, busy); end
    checks++; if (err_cnt !== CW'(exp_err)) begin errors++; $display("FAIL ch_err got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_random();
    int busy, dn, k; logic tmo; logic [3:0] mask; logic [9:0] v;
    int exp_w[$];
    for (int p = 0; p < 4; p++) begin
      exp_w.delete();
      mask = 4'($urandom_range(15));
      for (int a = 0; a < NW; a++) begin
        if (mask[a]) begin
          v = 10'($urandom_range(1023));
          if (v == gold(a)) v = v ^ 10'h001;
          host_op(1'b1, a, v);
          exp_w.push_back(a);
        end
      end
      k = exp_w.size();
      force_pass();
      watch_pass(30, busy, dn, tmo);
      exp_err = sat_add(exp_err, k);
      checks++; if (tmo || dn != 1) begin errors++; $display("FAIL rnd_done p=%0d got tmo=%b dn=%0d", p, tmo, dn); end
      checks++; if (wr_addr_q != exp_w) begin errors++; $display("FAIL rnd_wr p=%0d got n=%0d want n=%0d", p, wr_addr_q.size(), k); end
      checks++; if (busy < 2 * NW + k) begin errors++; $display("FAIL rnd_len p=%0d got %0d want >=%0d", p, busy, 2 * NW + k); end
      for (int a = 0; a < NW; a++) begin
        checks++; if (mem[a] !== gold(a)) begin errors++; $display("FAIL rnd_mem p=%0d a=%0d got %h want %h", p, a, mem[a], gold(a)); end
      end
      foreach (wr_data_q[i]) begin
        checks++; if (wr_data_q[i] !== gold(wr_addr_q[i])) begin errors++; $display("FAIL rnd_wdata got %h want %h", wr_data_q[i], gold(wr_addr_q[i])); end
      end
      checks++; if (err_cnt !== CW'(exp_err)) begin errors++; $display("FAIL rnd_err p=%0d got %0d want %0d", p, err_cnt, exp_err); end
    end
  endtask

  task automatic test_saturate();
    int busy, dn; logic tmo;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < NW; a++) host_op(1'b1, a, ~gold(a));
      force_pass();
      watch_pass(0, busy, dn, tmo);
      exp_err = sat_add(exp_err, NW);
      checks++; if (tmo || dn != 1 || busy != 3 * NW || wr_addr_q.size() != NW)
        begin errors++; $display("FAIL sat_pass p=%0d got tmo=%b busy=%0d nwr=%0d", p, tmo, busy, wr_addr_q.size()); end
      checks++; if (err_cnt !== CW'(exp_err)) begin errors++; $display("FAIL sat_err p=%0d got %0d want %0d", p, err_cnt, exp_err); end
    end
  endtask

  task automatic test_reset_in_wr();
    logic found = 1'b0;
    host_op(1'b1, 1, GE);
    force_pass();
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (bus.ram_wr_en) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rw_reach_wr got no write within 20 cycles want one");
    end else begin
      rst_n = 1'b0;
      #1;
      checks++; if (bus.ram_wr_en !== 1'b0) begin errors++; $display("FAIL rw_async_wr got %b want 0", bus.ram_wr_en); end
      checks++; if (scrub_busy !== 1'b0 || err_cnt !== '0) begin errors++; $display("FAIL rw_async_state got busy=%b err=%0d want 0 0", scrub_busy, err_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (scrub_busy !== 1'b0 || err_cnt !== '0 || bus.ram_rd_en !== 1'b0 || bus.ram_wr_en !== 1'b0)
        begin errors++; $display("FAIL rw_after got busy=%b err=%0d rd=%b wr=%b want all 0", scrub_busy, err_cnt, bus.ram_rd_en, bus.ram_wr_en); end
      checks++; if (mem[1] !== GE) begin errors++; $display("FAIL rw_ram got %h want %h", mem[1], GE); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; scrub_en = 1'b0; scrub_force = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    test_reset();
    test_periodic();
    test_force_correct();
    test_host_stall();
    test_cmp_host();
    test_random();
    test_saturate();
    test_reset_in_wr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
